// File: rtl/phase_timer_pkg.sv
// Shared encodings for the phase timer: phase modes and controller states.
package phase_timer_pkg;

  localparam logic [1:0] MODE_GREEN  = 2'b00;
  localparam logic [1:0] MODE_YELLOW = 2'b01;
  localparam logic [1:0] MODE_ALLRED = 2'b10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // The unused encoding 11 is folded onto all-red, the safest phase.
  function automatic logic [1:0] norm_mode(input logic [1:0] m);
    logic [1:0] r;
    if (m == 2'b11) begin
      r = MODE_ALLRED;
    end else begin
      r = m;
    end
    return r;
  endfunction

endpackage

// File: rtl/phase_timer_tick_prescaler.sv
// Divides the clock into timer ticks; counts only while enabled so a hold
// freezes the phase of the divider as well as the countdown.
module tick_prescaler #(
  parameter int TICK_DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int             CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0]  LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_r;

  // With TICK_DIV=1 the counter is pinned at zero, so tick simply follows en.
  assign tick = en && (cnt_r == LAST);

  // Divider count: cleared on (re)start, wraps after the terminal count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= {CW{1'b0}};
    end else if (clr) begin
      cnt_r <= {CW{1'b0}};
    end else if (tick) begin
      cnt_r <= {CW{1'b0}};
    end else if (en) begin
      cnt_r <= cnt_r + CW'(1'b1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/phase_timer.sv
// Per-phase countdown timer with tick prescaler, capped green extension,
// hold, abort and handshake pulses. All outputs come straight from flops.
module phase_timer
  import phase_timer_pkg::*;
#(
  parameter int CNT_W     = 8,
  parameter int TICK_DIV  = 1,
  parameter int GREEN_DEF = 20,
  parameter int EXT_STEP  = 10,
  parameter int GREEN_MAX = 30,
  parameter int YELLOW_T  = 5,
  parameter int ALLRED_T  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic             hold,
  input  logic             abort,
  input  logic             ext_req,
  output logic             busy,
  output logic             expired,
  output logic [CNT_W-1:0] remaining,
  output logic [1:0]       cur_mode,
  output logic             ext_ack,
  output logic             ext_sat
);

  if (GREEN_MAX >= (1 << CNT_W)) begin : g_cnt_w_too_narrow
    $error("phase_timer: CNT_W cannot hold GREEN_MAX");
  end
  if (TICK_DIV < 1) begin : g_tick_div_invalid
    $error("phase_timer: TICK_DIV must be at least 1");
  end

  localparam logic [CNT_W-1:0] GREEN_DEF_C = CNT_W'(GREEN_DEF);
  localparam logic [CNT_W-1:0] YELLOW_C    = CNT_W'(YELLOW_T);
  localparam logic [CNT_W-1:0] ALLRED_C    = CNT_W'(ALLRED_T);
  localparam logic [CNT_W-1:0] ZERO_C      = {CNT_W{1'b0}};
  // Extension math runs one bit wider so remaining - tick + grant never wraps.
  localparam int               EXT_CAP     = (EXT_STEP > GREEN_MAX) ? GREEN_MAX : EXT_STEP;
  localparam logic [CNT_W:0]   GREEN_MAX_W = (CNT_W + 1)'(GREEN_MAX);
  localparam logic [CNT_W:0]   EXT_STEP_W  = (CNT_W + 1)'(EXT_CAP);
  localparam logic [CNT_W:0]   ZERO_W      = {(CNT_W + 1){1'b0}};
  localparam logic             SAT_ON_LOAD = (GREEN_DEF == GREEN_MAX);

  state_e           state_r, state_s;
  logic [CNT_W-1:0] remaining_r, remaining_s;
  logic [CNT_W-1:0] green_total_r, green_total_s;
  logic [1:0]       cur_mode_r, cur_mode_s;
  logic             busy_r, busy_s;
  logic             expired_r, expired_s;
  logic             ext_ack_r, ext_ack_s;
  logic             ext_sat_r, ext_sat_s;

  logic [1:0]       start_mode_s;
  logic [CNT_W-1:0] load_dur_s;
  logic             tick_s;
  logic             presc_en_s;
  logic             presc_clr_s;
  logic             ext_ok_s;
  logic [CNT_W:0]   headroom_s;
  logic [CNT_W:0]   grant_s;
  logic [CNT_W:0]   rem_wide_s;
  logic [CNT_W:0]   green_wide_s;

  assign presc_en_s  = (state_r == ST_RUN) && !hold;
  assign presc_clr_s = start || abort;

  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_presc (
    .clk (clk),
    .rst (rst),
    .clr (presc_clr_s),
    .en  (presc_en_s),
    .tick(tick_s)
  );

  // Phase length selected by the mode presented alongside start.
  always_comb begin
    start_mode_s = norm_mode(mode);
    case (start_mode_s)
      MODE_GREEN:  load_dur_s = GREEN_DEF_C;
      MODE_YELLOW: load_dur_s = YELLOW_C;
      default:     load_dur_s = ALLRED_C;
    endcase
  end

  // Extension grant clipped to the remaining green headroom, plus the
  // widened next-value arithmetic for the countdown and green total.
  always_comb begin
    headroom_s = GREEN_MAX_W - {1'b0, green_total_r};
    ext_ok_s   = (state_r == ST_RUN) && (cur_mode_r == MODE_GREEN) && ext_req;
    if (!ext_ok_s) begin
      grant_s = ZERO_W;
    end else if (headroom_s < EXT_STEP_W) begin
      grant_s = headroom_s;
    end else begin
      grant_s = EXT_STEP_W;
    end
    rem_wide_s   = {1'b0, remaining_r} - {{CNT_W{1'b0}}, tick_s} + grant_s;
    green_wide_s = {1'b0, green_total_r} + grant_s;
  end

  // Next-state and next-output logic; abort outranks start, start outranks
  // the running countdown.
  always_comb begin
    state_s       = state_r;
    remaining_s   = remaining_r;
    green_total_s = green_total_r;
    cur_mode_s    = cur_mode_r;
    busy_s        = busy_r;
    expired_s     = 1'b0;
    ext_ack_s     = 1'b0;
    ext_sat_s     = ext_sat_r;
    if (abort) begin
      state_s       = ST_IDLE;
      remaining_s   = ZERO_C;
      green_total_s = ZERO_C;
      busy_s        = 1'b0;
      ext_sat_s     = 1'b0;
    end else if (start) begin
      state_s     = ST_RUN;
      remaining_s = load_dur_s;
      cur_mode_s  = start_mode_s;
      busy_s      = 1'b1;
      if (start_mode_s == MODE_GREEN) begin
        green_total_s = GREEN_DEF_C;
        ext_sat_s     = SAT_ON_LOAD;
      end else begin
        green_total_s = ZERO_C;
        ext_sat_s     = 1'b0;
      end
    end else begin
      case (state_r)
        ST_RUN: begin
          green_total_s = green_wide_s[CNT_W-1:0];
          ext_ack_s     = (grant_s != ZERO_W);
          if (rem_wide_s == ZERO_W) begin
            state_s     = ST_IDLE;
            remaining_s = ZERO_C;
            busy_s      = 1'b0;
            expired_s   = 1'b1;
            ext_sat_s   = 1'b0;
          end else begin
            remaining_s = rem_wide_s[CNT_W-1:0];
            ext_sat_s   = (cur_mode_r == MODE_GREEN) && (green_wide_s == GREEN_MAX_W);
          end
        end
        ST_IDLE: begin
          state_s = ST_IDLE;
        end
        default: begin
          state_s     = ST_IDLE;
          remaining_s = ZERO_C;
          busy_s      = 1'b0;
          ext_sat_s   = 1'b0;
        end
      endcase
    end
  end

  // State and output registers; async reset clears everything at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      remaining_r   <= ZERO_C;
      green_total_r <= ZERO_C;
      cur_mode_r    <= MODE_GREEN;
      busy_r        <= 1'b0;
      expired_r     <= 1'b0;
      ext_ack_r     <= 1'b0;
      ext_sat_r     <= 1'b0;
    end else begin
      state_r       <= state_s;
      remaining_r   <= remaining_s;
      green_total_r <= green_total_s;
      cur_mode_r    <= cur_mode_s;
      busy_r        <= busy_s;
      expired_r     <= expired_s;
      ext_ack_r     <= ext_ack_s;
      ext_sat_r     <= ext_sat_s;
    end
  end

  assign busy      = busy_r;
  assign expired   = expired_r;
  assign remaining = remaining_r;
  assign cur_mode  = cur_mode_r;
  assign ext_ack   = ext_ack_r;
  assign ext_sat   = ext_sat_r;

endmodule

// File: doc/phase_timer.md
Name: phase_timer

Overview:
Parametrised successor to the single-purpose light timer. It is a countdown timer per signal phase with three modes (green, yellow, all-red) and a tick prescaler. Green extension is granted in capped increments. The block also supports hold/pause, abort, a remaining-time readout, and handshake pulses. It sits between the traffic-light FSM (start/mode/abort) and the sensor logic (ext_req).

Parameters:
CNT_W, 8, width of remaining/elapsed counters; must hold GREEN_MAX (elaboration check).
TICK_DIV, 1, clocks per timer tick (1 = count every clock); must be >= 1.
GREEN_DEF, 20, base green duration in ticks (>= 1).
EXT_STEP, 10, ticks added per granted extension (>= 1).
GREEN_MAX, 30, cap on total green duration in ticks (>= GREEN_DEF).
YELLOW_T, 5, yellow duration in ticks (>= 1).
ALLRED_T, 2, all-red clearance duration in ticks (>= 1).

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  load the duration for mode and run; 1-cycle pulse expected
mode  in  2  phase select sampled at start: 00 green, 01 yellow, 10 all-red, 11 treated as all-red
hold  in  1  level; freezes countdown and prescaler while high
abort  in  1  cancel the running phase without expiry
ext_req  in  1  request green extension; sampled every cycle
busy  out  1  high while a phase is running
expired  out  1  1-cycle pulse at natural end of phase
remaining  out  CNT_W  ticks left in the current phase
cur_mode  out  2  mode latched at start (11 stored as 10)
ext_ack  out  1  1-cycle pulse when an extension is granted
ext_sat  out  1  high when green total == GREEN_MAX; cleared on start/abort

Behaviour:
- Reset (async): all outputs 0; FSM goes to IDLE; prescaler and green-total counter are cleared. Reset mid-run drops busy in the same cycle and produces no expired pulse.
- FSM states: IDLE, RUN.
- IDLE -> RUN on start: remaining <= duration(mode); cur_mode latched; prescaler cleared; green_total <= GREEN_DEF if green; busy <= 1.
- start while in RUN: restart with the new mode and duration, no expired pulse.
- abort has priority over start: in any state, go to IDLE with busy=0, remaining=0, no expired pulse.
- Tick: the prescaler counts clocks 0..TICK_DIV-1 while in RUN and hold=0. A tick (dec=1) occurs when the prescaler is at TICK_DIV-1, and the prescaler then wraps to 0. Hold freezes the prescaler value.
- Extension: applies only in RUN with cur_mode=green and ext_req=1, including while hold=1.
  - grant = min(EXT_STEP, GREEN_MAX - green_total).
  - If grant > 0: ext_ack pulse and green_total += grant.
  - If grant = 0: no ack.
  - ext_req in IDLE, yellow or all-red is ignored.
- Update rule in RUN: remaining_next = remaining - dec + grant. The arithmetic is done in CNT_W+1 bits internally and never wraps.
- Expiry: if remaining_next == 0, then expired = 1 for one cycle, busy = 0, state goes to IDLE. An extension granted on the terminal tick therefore suppresses expiry.
- Latency: with TICK_DIV=1 and no hold or extension, start sampled at edge k gives expired high after edge k+D. With hold, the expiry point moves out by the number of held cycles.
- ext_sat = (green_total == GREEN_MAX) while cur_mode=green and busy; otherwise 0.
- mode changes while in RUN are ignored until the next start.

Decomposition:
- Package phase_timer_pkg holds:
  - mode encodings MODE_GREEN, MODE_YELLOW, MODE_ALLRED;
  - FSM state encodings.
- One sub-module, tick_prescaler: parameter TICK_DIV; inputs clk, rst, clr, en; output tick. For TICK_DIV=1, tick = en combinationally.

Test Plan:
- Green base: reset, start with mode=00 at edge 0 -> remaining=20, busy=1; expired single pulse after edge 20; busy=0, remaining=0.
- Green extend and cap: ext_req at edge 5 -> ext_ack, remaining=25, expiry at edge 30. Second ext_req at edge 10 -> no ack, ext_sat=1, expiry stays at edge 30.
- Extend on terminal tick: green start, ext_req at edge 20 only -> no expired at 20, remaining=10, ext_ack, expired at edge 30.
- Yellow with hold: mode=01, hold high for edges 2-4 -> remaining frozen, expired at edge 8; ext_req during yellow gives no ack.
- Abort/reset: abort and start together at edge 7 of green -> busy=0, remaining=0, no expired ever. rst asserted mid-run -> all outputs 0 before the next clk edge.
- Prescaler/mode 11: TICK_DIV=4, mode=11 -> cur_mode=10, remaining=2, decrements at edges 4 and 8, expired after edge 8.
